// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter must hold values 0..w, and is never narrower than one bit.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w + 1);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake and operand/result bus of the serial subtractor.
// start is taken only on an edge where ready=1; done marks the single cycle in
// which diff/bout have just been updated; results hold until the next done.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    import arith_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    state_t           dbg_state;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, bout, dbg_state
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, bout, dbg_state
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    output logic d,
    output logic bout,
    input  logic x,
    input  logic y,
    input  logic bin
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_subtractor_if.slave bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff_q;
    logic             borrow;
    logic             bout_q;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bnext;
    logic             last_bit;

    full_subtractor u_fs (
        .d    (d),
        .bout (bnext),
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    assign res_nxt  = WIDTH'({d, res} >> 1);
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (last_bit)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        res    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res    <= res_nxt;
                    borrow <= bnext;
                    cnt    <= cnt + 1'b1;
                    // Publish on the edge that enters DONE, using the final bit.
                    if (last_bit) begin
                        diff_q <= res_nxt;
                        bout_q <= bnext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = (state == S_IDLE);
    assign bus.busy      = (state == S_RUN);
    assign bus.done      = (state == S_DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=1, 8 and 16: directed vectors, handshake
// corner sequences and a randomized sweep against an arithmetic reference.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(1))  if1 ();
    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(16)) if16 ();

    serial_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic s, input logic [31:0] av, input logic [31:0] bv);
        case (sel)
            1:       begin if1.start  = s; if1.a  = 1'(av);  if1.b  = 1'(bv);  end
            8:       begin if8.start  = s; if8.a  = 8'(av);  if8.b  = 8'(bv);  end
            default: begin if16.start = s; if16.a = 16'(av); if16.b = 16'(bv); end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            1:       return if1.done;
            8:       return if8.done;
            default: return if16.done;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            1:       return if1.ready;
            8:       return if8.ready;
            default: return if16.ready;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1:       return if1.busy;
            8:       return if8.busy;
            default: return if16.busy;
        endcase
    endfunction

    function automatic logic get_bout(input int sel);
        case (sel)
            1:       return if1.bout;
            8:       return if8.bout;
            default: return if16.bout;
        endcase
    endfunction

    function automatic logic [31:0] get_diff(input int sel);
        case (sel)
            1:       return 32'(if1.diff);
            8:       return 32'(if8.diff);
            default: return 32'(if16.diff);
        endcase
    endfunction

    // Waits for done; lat counts rising edges from acceptance to the first edge
    // that sees done high. Returns at the falling edge where done is visible.
    task automatic wait_done(input int sel, input string name, output int lat);
        int n;
        n = 1;
        while (!get_done(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!get_done(sel)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        lat = n;
    endtask

    task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] dv, output logic bo, output int lat);
        @(negedge clk);
        set_in(sel, 1'b1, av, bv);
        @(posedge clk);
        @(negedge clk);
        set_in(sel, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        wait_done(sel, "run_op", lat);
        dv = get_diff(sel);
        bo = get_bout(sel);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [5];
        logic [31:0] dv;
        logic        bo;
        int          lat;
        int          n;
        int          extra_done;
        logic [31:0] ra, rb;
        logic [32:0] ref_full;

        vecs[0] = '{a: 8'd100, b: 8'd37,  diff: 8'd63,  bout: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd9,   diff: 8'hFC,  bout: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd1,   diff: 8'hFF,  bout: 1'b1};
        vecs[3] = '{a: 8'd255, b: 8'd255, diff: 8'h00,  bout: 1'b0};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   diff: 8'h00,  bout: 1'b0};

        // Clock/reset block
        rst_n = 1'b0;
        set_in(1, 1'b0, 0, 0);
        set_in(8, 1'b0, 0, 0);
        set_in(16, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            int sel;
            sel = (s == 0) ? 1 : ((s == 1) ? 8 : 16);
            check("reset_ready", 64'(get_ready(sel)), 64'd1);
            check("reset_busy",  64'(get_busy(sel)),  64'd0);
            check("reset_done",  64'(get_done(sel)),  64'd0);
            check("reset_diff",  64'(get_diff(sel)),  64'd0);
            check("reset_bout",  64'(get_bout(sel)),  64'd0);
        end
        rst_n = 1'b1;

        // Directed vectors, WIDTH=8
        for (int i = 0; i < 5; i++) begin
            run_op(8, 32'(vecs[i].a), 32'(vecs[i].b), dv, bo, lat);
            check("vec_diff",    64'(dv),  64'(vecs[i].diff));
            check("vec_bout",    64'(bo),  64'(vecs[i].bout));
            check("vec_latency", 64'(lat), 64'd9);
            @(negedge clk);
            check("vec_done_single", 64'(get_done(8)),  64'd0);
            check("vec_ready_back",  64'(get_ready(8)), 64'd1);
        end

        // start pulse with new operands mid-RUN is ignored
        @(negedge clk);
        set_in(8, 1'b1, 200, 50);
        @(posedge clk);
        @(negedge clk);
        set_in(8, 1'b0, 0, 0);
        for (n = 1; n <= 12; n++) begin
            if (n == 3) set_in(8, 1'b1, 10, 3);
            if (n == 4) set_in(8, 1'b0, 0, 0);
            check("midrun_busy", 64'(get_busy(8)), 64'(n <= 8));
            check("midrun_done", 64'(get_done(8)), 64'(n == 9));
            if (n == 9) begin
                check("midrun_diff", 64'(get_diff(8)), 64'd150);
                check("midrun_bout", 64'(get_bout(8)), 64'd0);
            end
            @(negedge clk);
        end
        check("midrun_diff_hold", 64'(get_diff(8)), 64'd150);

        // Reset in the middle of 77-11
        set_in(8, 1'b1, 77, 11);
        @(posedge clk);
        @(negedge clk);
        set_in(8, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_done",  64'(get_done(8)),  64'd0);
        check("rst_mid_diff",  64'(get_diff(8)),  64'd0);
        check("rst_mid_bout",  64'(get_bout(8)),  64'd0);
        check("rst_mid_ready", 64'(get_ready(8)), 64'd1);
        check("rst_mid_busy",  64'(get_busy(8)),  64'd0);
        extra_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (get_done(8)) extra_done++;
        end
        check("rst_mid_no_done", 64'(extra_done), 64'd0);
        run_op(8, 77, 11, dv, bo, lat);
        check("after_rst_diff",    64'(dv),  64'd66);
        check("after_rst_bout",    64'(bo),  64'd0);
        check("after_rst_latency", 64'(lat), 64'd9);

        // start held high across two back-to-back operations
        @(negedge clk);
        set_in(8, 1'b1, 20, 30);
        @(posedge clk);
        @(negedge clk);
        set_in(8, 1'b1, 30, 20);
        wait_done(8, "held_first", lat);
        check("held_first_lat",  64'(lat),            64'd9);
        check("held_first_diff", 64'(get_diff(8)),    64'hF6);
        check("held_first_bout", 64'(get_bout(8)),    64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!get_done(8) && n < 50);
        check("held_spacing",     64'(n),          64'd10);
        check("held_second_diff", 64'(get_diff(8)), 64'd10);
        check("held_second_bout", 64'(get_bout(8)), 64'd0);
        set_in(8, 1'b0, 0, 0);
        @(negedge clk);
        check("held_ready_back", 64'(get_ready(8)), 64'd1);

        // Randomized sweep against {bout,diff} = {0,a} - {0,b}
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom_range(0, 65535);
            rb = (i % 16 == 0) ? ra : $urandom_range(0, 65535);
            ref_full = {17'd0, ra[15:0]} - {17'd0, rb[15:0]};
            run_op(16, ra, rb, dv, bo, lat);
            check("rand16_diff", 64'(dv),  64'(ref_full[15:0]));
            check("rand16_bout", 64'(bo),  64'(ref_full[16]));
            check("rand16_lat",  64'(lat), 64'd17);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 32'($urandom_range(0, 1));
            rb = 32'($urandom_range(0, 1));
            ref_full = {32'd0, ra[0]} - {32'd0, rb[0]};
            run_op(1, ra, rb, dv, bo, lat);
            check("rand1_diff", 64'(dv),  64'(ref_full[0]));
            check("rand1_bout", 64'(bo),  64'(ref_full[1]));
            check("rand1_lat",  64'(lat), 64'd2);
        end

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
